// File: rtl/tipos_pacotes.sv
// -----------------------------------------------------------------------------
// tipos_pacotes
// Shared types and constants for the BCD packet interface between the
// binary-to-BCD converter (producer) and the 7-segment display driver.
//   bcdPac_t     : six 4-bit digit codes, BCD5 most significant
//   conv_state_t : converter FSM states
// Digit codes: 4'h0..4'h9 numerals, BCD_DASH = 4'hA, BCD_BLANK = 4'hB.
// -----------------------------------------------------------------------------
package tipos_pacotes;

  localparam logic [3:0]  BCD_DASH      = 4'hA;
  localparam logic [3:0]  BCD_BLANK     = 4'hB;
  localparam int unsigned BCD_MAX_VALUE = 999999;

  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FORMAT,
    DONE
  } conv_state_t;

endpackage

// File: rtl/bin_to_bcd_packet_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational digit adjust step of the shift-add-3 algorithm: a digit of 5 or
// more gets 3 added so that the following left shift carries into the next
// decade correctly.
//   i_digit : 4-bit BCD digit before adjust
//   o_digit : adjusted digit (i_digit >= 5 ? i_digit + 3 : i_digit)
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_packet.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_packet
// Iterative double-dabble converter from an unsigned binary value to a six-digit
// bcdPac_t packet for the display driver. Leading zeros may be blanked and
// values above 999999 are shown as six dashes. Latency from the accepting edge
// to the done pulse is fixed at WIDTH+2 clocks.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   start      : conversion request, accepted only while ready=1
//   value      : binary operand, sampled on the accepting edge
//   clear      : drops enable_o on the next edge
//   ready      : high while idle
//   done       : one-cycle pulse, coincident with a new bcd_packet
//   enable_o   : level, set by done, cleared by clear or rst
//   bcd_packet : registered result, held between conversions
// -----------------------------------------------------------------------------
module bin_to_bcd_packet
  import tipos_pacotes::*;
#(
  parameter int unsigned WIDTH    = 20,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             clear,
  output logic             ready,
  output logic             done,
  output logic             enable_o,
  output bcdPac_t          bcd_packet
);

  localparam int unsigned CntW = $clog2(WIDTH);

  conv_state_t      r_state;
  conv_state_t      w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [23:0]      r_acc;
  logic [CntW-1:0]  r_cnt;
  logic             r_ovf;
  logic [23:0]      r_fmt;
  logic             r_done;
  logic             r_enable;
  logic [23:0]      r_packet;
  logic [23:0]      w_adj;
  logic [23:0]      w_fmt;

  // Six parallel digit adjusts on the accumulator
  for (genvar g = 0; g < 6; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = CONVERT;
      CONVERT: if (r_cnt == '0) w_state_next = FORMAT;
      FORMAT:  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready      = (r_state == IDLE);
    done       = r_done;
    enable_o   = r_enable;
    bcd_packet = r_packet;
  end

  // Formatting: dashes on overflow, otherwise optional leading-zero blanking
  // from BCD5 downwards; BCD0 always stays numeric.
  always_comb begin
    logic lead;
    w_fmt = r_acc;
    lead  = 1'b1;
    if (r_ovf) begin
      w_fmt = {6{BCD_DASH}};
    end else if (LZ_BLANK) begin
      for (int i = 5; i >= 1; i--) begin
        if (lead && (r_acc[4*i +: 4] == 4'h0)) begin
          w_fmt[4*i +: 4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_fmt    <= {6{BCD_BLANK}};
      r_done   <= 1'b0;
      r_enable <= 1'b0;
      r_packet <= {6{BCD_BLANK}};
    end else begin
      r_done <= 1'b0;
      // A DONE in the same cycle overrides this below
      if (clear) begin
        r_enable <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= value;
            r_acc   <= '0;
            r_cnt   <= CntW'(WIDTH - 1);
            r_ovf   <= (32'(value) > BCD_MAX_VALUE);
          end
        end
        CONVERT: begin
          // Adjust then shift {acc, shift} left by one
          r_acc   <= {w_adj[22:0], r_shift[WIDTH-1]};
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - 1'b1;
        end
        FORMAT: begin
          r_fmt <= w_fmt;
        end
        DONE: begin
          r_packet <= r_fmt;
          r_done   <= 1'b1;
          r_enable <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_packet.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_packet
// Bench for bin_to_bcd_packet. Two instances share all inputs: one with leading
// zero blanking, one without. Expected packets come from a decimal arithmetic
// model of the displayed digits.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_packet;

  localparam int unsigned W   = 20;
  localparam int unsigned LAT = W + 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  value;
  logic          clear;
  logic          ready;
  logic          done;
  logic          enable_o;
  logic [23:0]   pkt;
  logic          ready_nz;
  logic          done_nz;
  logic          enable_nz;
  logic [23:0]   pkt_nz;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_packet #(.WIDTH(W), .LZ_BLANK(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .value      (value),
    .clear      (clear),
    .ready      (ready),
    .done       (done),
    .enable_o   (enable_o),
    .bcd_packet (pkt)
  );

  bin_to_bcd_packet #(.WIDTH(W), .LZ_BLANK(1'b0)) dut_nz (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .value      (value),
    .clear      (clear),
    .ready      (ready_nz),
    .done       (done_nz),
    .enable_o   (enable_nz),
    .bcd_packet (pkt_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Displayed digits derived with decimal arithmetic
  function automatic logic [23:0] model(input int unsigned v, input bit lz);
    logic [23:0] r;
    int unsigned x;
    bit lead;
    r    = '0;
    x    = v;
    lead = 1'b1;
    if (v > 999999) begin
      r = {6{4'hA}};
    end else begin
      for (int i = 0; i < 6; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
      if (lz) begin
        for (int i = 5; i >= 1; i--) begin
          if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hB;
          else lead = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept v, wait for done, check latency, packets and enable
  task automatic run_conv(input int unsigned v, input string tag);
    int n;
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    start = 1'b1;
    value = W'(v);
    step();
    start = 1'b0;
    value = W'($urandom);
    check_eq({tag, "_busy"}, 32'(ready), 32'd0);
    n = 1;
    step();
    while (!done && n < 40) begin
      step();
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(LAT));
    check_eq({tag, "_pkt_lz"}, 32'(pkt), 32'(model(v, 1'b1)));
    check_eq({tag, "_pkt_nolz"}, 32'(pkt_nz), 32'(model(v, 1'b0)));
    check_eq({tag, "_enable"}, 32'(enable_o), 32'd1);
    step();
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    int unsigned v;
    logic [23:0] held;

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    clear = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_enable", 32'(enable_o), 32'd0);
    check_eq("rst_pkt", 32'(pkt), 32'hBBBBBB);
    check_eq("rst_pkt_nolz", 32'(pkt_nz), 32'hBBBBBB);

    run_conv(123456, "v123456");
    run_conv(42, "v42");
    run_conv(0, "v0");
    run_conv(999999, "v999999");
    run_conv(1000000, "v1000000");

    // Second start during a conversion is ignored
    start = 1'b1;
    value = W'(100);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1;
    value = W'(777);
    step();
    start = 1'b0;
    n = 5;
    dones = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check_eq("ignore_latency", 32'(n), 32'(LAT));
    check_eq("ignore_pkt", 32'(pkt), 32'hBBB100);
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      step();
    end
    check_eq("ignore_done_count", 32'(dones), 32'd1);

    // Reset in the middle of a conversion
    start = 1'b1;
    value = W'(555);
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_enable", 32'(enable_o), 32'd0);
    check_eq("abort_pkt", 32'(pkt), 32'hBBBBBB);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      step();
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);

    // clear after completion
    run_conv(31415, "vclear");
    held = model(31415, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clear_enable", 32'(enable_o), 32'd0);
    check_eq("clear_pkt", 32'(pkt), 32'(held));

    // clear sampled on the same edge that raises done
    start = 1'b1;
    value = W'(8);
    step();
    start = 1'b0;
    for (int i = 0; i < LAT - 1; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clear_done_done", 32'(done), 32'd1);
    check_eq("clear_done_enable", 32'(enable_o), 32'd1);
    check_eq("clear_done_pkt", 32'(pkt), 32'hBBBBB8);
    step();

    // Random values, including out-of-range ones above 999999
    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 0) v = $urandom_range(0, 999);
      else v = $urandom & 32'hFFFFF;
      run_conv(v, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
